// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the 64-point FFT front end.
package fft_pkg;

  localparam int unsigned FFT_GROUP_WORDS = 8;
  localparam int unsigned FFT_WORD_WIDTH  = 32;
  localparam int unsigned FFT_HALF_WIDTH  = 16;

  // FILL: collecting words; FULL: a completed group is parked behind an unacknowledged bank
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

endpackage : fft_pkg

// File: rtl/input_swap.sv
// Combinational real/imaginary half-swap of a complex word.
//   swap_en : 1 = exchange upper (real) and lower (imaginary) halves
//   din     : complex word in
//   dout_c  : complex word out (combinational)
module input_swap #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             swap_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  localparam int unsigned H = WIDTH / 2;

  assign dout_c = swap_en ? {din[H-1:0], din[WIDTH-1:H]} : din;

endmodule : input_swap

// File: rtl/input_circuit.sv
// Serial-to-parallel front end of the 64-point FFT: collects 8 complex words
// and presents them as a parallel group Q0..Q7 with a valid/ack handshake.
//   clk, rst          : clock, synchronous active-high reset
//   mode              : 1 = inverse transform, swap real/imag of each accepted word
//   in_valid/in_ready : serial input handshake, D carries the word
//   frame_clr         : discard a partially collected group (and any parked group)
//   out_valid/out_ack : parallel output handshake for Q0..Q7 (Q0 = first word)
//   word_cnt          : words collected in the current group
module input_circuit
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFT_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  frame_clr,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic [DATA_WIDTH-1:0] Q0,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic [DATA_WIDTH-1:0] Q2,
  output logic [DATA_WIDTH-1:0] Q3,
  output logic [DATA_WIDTH-1:0] Q4,
  output logic [DATA_WIDTH-1:0] Q5,
  output logic [DATA_WIDTH-1:0] Q6,
  output logic [DATA_WIDTH-1:0] Q7,
  output logic [2:0]            word_cnt
);

  localparam int unsigned NSH = FFT_GROUP_WORDS - 1;

  fill_state_e                                  state_q, state_d;
  logic [NSH-1:0][DATA_WIDTH-1:0]               sh_q, sh_d;
  logic [DATA_WIDTH-1:0]                        park_q, park_d;
  logic [FFT_GROUP_WORDS-1:0][DATA_WIDTH-1:0]   bank_q, bank_d;
  logic                                         out_valid_q, out_valid_d;
  logic                                         in_ready_q, in_ready_d;
  logic [2:0]                                   word_cnt_q, word_cnt_d;

  logic [DATA_WIDTH-1:0] word_c;
  logic                  accept_c;

  input_swap #(.WIDTH(DATA_WIDTH)) u_swap (
    .swap_en (mode),
    .din     (D),
    .dout_c  (word_c)
  );

  assign accept_c = in_valid && in_ready_q;

  // Next-state: shifter, parking register, bank and handshake flags
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    park_d      = park_q;
    bank_d      = bank_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;

    // A taken group clears valid unless a new group loads on the same edge
    if (out_ack && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    if (frame_clr) begin
      word_cnt_d = 3'd0;
      state_d    = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept_c) begin
            if (word_cnt_q != 3'd7) begin
              for (int i = 0; i < int'(NSH) - 1; i++) begin
                sh_d[i] = sh_q[i+1];
              end
              sh_d[NSH-1] = word_c;
              word_cnt_d  = word_cnt_q + 3'd1;
            end else if (!out_valid_q || out_ack) begin
              bank_d      = {word_c, sh_q};
              out_valid_d = 1'b1;
              word_cnt_d  = 3'd0;
            end else begin
              // Bank still owned by consumer: hold the eighth word until ack
              park_d  = word_c;
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (out_ack) begin
            bank_d      = {park_q, sh_q};
            out_valid_d = 1'b1;
            word_cnt_d  = 3'd0;
            state_d     = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end

    in_ready_d = (state_d == FILL);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      sh_q        <= '0;
      park_q      <= '0;
      bank_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      word_cnt_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      park_q      <= park_d;
      bank_q      <= bank_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign word_cnt  = word_cnt_q;
  assign Q0 = bank_q[0];
  assign Q1 = bank_q[1];
  assign Q2 = bank_q[2];
  assign Q3 = bank_q[3];
  assign Q4 = bank_q[4];
  assign Q5 = bank_q[5];
  assign Q6 = bank_q[6];
  assign Q7 = bank_q[7];

endmodule : input_circuit

// File: tb/tb_input_circuit.sv
// Self-checking bench for input_circuit: table-driven groups, directed
// corner sequences and a randomized scoreboard run.
module tb_input_circuit;
  import fft_pkg::*;

  localparam int unsigned W = FFT_WORD_WIDTH;
  typedef logic [7:0][W-1:0] grp_t;

  typedef struct {
    logic [7:0] mode_mask;
    grp_t       words;
    grp_t       exp;
  } vec_t;

  logic         clk, rst, mode, in_valid, in_ready, frame_clr, out_valid, out_ack;
  logic [W-1:0] D, Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [2:0]   word_cnt;
  grp_t         q_now;

  int tests = 0;
  int fails = 0;
  grp_t sb[$];
  vec_t vecs[3];

  assign q_now = {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};

  input_circuit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .frame_clr(frame_clr), .out_valid(out_valid), .out_ack(out_ack),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
    .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] swp(input logic [W-1:0] w);
    return {w[W/2-1:0], w[W-1:W/2]};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_group(input string nm, input grp_t exp);
    for (int i = 0; i < 8; i++) chk($sformatf("%s Q%0d", nm, i), q_now[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; frame_clr = 1'b0; out_ack = 1'b0; mode = 1'b0; D = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset word_cnt", W'(word_cnt), W'(0));
    chk("reset Q0", Q0, '0);
  endtask

  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1; D = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    grp_t g;
    int   sent, mcnt, cycles, taken;
    grp_t cur;

    // ---- vector table ----
    vecs[0].mode_mask = 8'h00;
    vecs[1].mode_mask = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      vecs[0].words[k-1] = {16'(k), 16'(k + 1)};
      vecs[0].exp[k-1]   = {16'(k), 16'(k + 1)};
      vecs[1].words[k-1] = {16'(k), 16'(k + 1)};
      vecs[1].exp[k-1]   = {16'(k + 1), 16'(k)};
      vecs[2].words[k-1] = 32'hAAAA_0000 + 32'(k - 1);
    end
    vecs[2].mode_mask = 8'h0F;
    vecs[2].exp[0] = 32'h0000_AAAA; vecs[2].exp[1] = 32'h0001_AAAA;
    vecs[2].exp[2] = 32'h0002_AAAA; vecs[2].exp[3] = 32'h0003_AAAA;
    vecs[2].exp[4] = 32'hAAAA_0004; vecs[2].exp[5] = 32'hAAAA_0005;
    vecs[2].exp[6] = 32'hAAAA_0006; vecs[2].exp[7] = 32'hAAAA_0007;

    do_reset();
    out_ack = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 8; i++) begin
        mode = vecs[v].mode_mask[i];
        D = vecs[v].words[i];
        in_valid = 1'b1;
        chk($sformatf("v%0d in_ready w%0d", v, i), W'(in_ready), W'(1));
        chk($sformatf("v%0d word_cnt w%0d", v, i), W'(word_cnt), W'(i));
        if (i == 7) begin
          chk($sformatf("v%0d out_valid early", v), W'(out_valid), W'(0));
          sb.push_back(vecs[v].exp);
        end
        tick();
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", v), W'(out_valid), W'(1));
      g = sb.pop_front();
      chk_group($sformatf("v%0d", v), g);
      tick();
      chk($sformatf("v%0d valid cleared", v), W'(out_valid), W'(0));
      chk($sformatf("v%0d Q0 retained", v), Q0, g[0]);
    end

    // ---- 16 words without ack: second group parks, FSM goes FULL ----
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("full in_ready w%0d", k), W'(in_ready), W'(1));
      send(32'h1000_0000 + 32'(k));
    end
    chk("full in_ready", W'(in_ready), W'(0));
    chk("full word_cnt", W'(word_cnt), W'(7));
    chk("full out_valid", W'(out_valid), W'(1));
    chk("full Q0 g1", Q0, 32'h1000_0001);
    chk("full Q7 g1", Q7, 32'h1000_0008);
    send(32'hBAD0_BAD0);
    chk("full ignores input", W'(in_ready), W'(0));
    chk("full Q0 stable", Q0, 32'h1000_0001);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("unpark Q0", Q0, 32'h1000_0009);
    chk("unpark Q7", Q7, 32'h1000_0010);
    chk("unpark out_valid", W'(out_valid), W'(1));
    chk("unpark in_ready", W'(in_ready), W'(1));
    chk("unpark word_cnt", W'(word_cnt), W'(0));

    // ---- frame_clr alongside a 6th word ----
    do_reset();
    for (int k = 1; k <= 5; k++) send(32'h5000_0000 + 32'(k));
    chk("pre-clr word_cnt", W'(word_cnt), W'(5));
    frame_clr = 1'b1;
    send(32'h5000_0006);
    frame_clr = 1'b0;
    chk("clr word_cnt", W'(word_cnt), W'(0));
    chk("clr out_valid", W'(out_valid), W'(0));
    for (int k = 0; k < 8; k++) begin
      g[k] = 32'hA0 + 32'(k);
      send(g[k]);
    end
    chk("clr group valid", W'(out_valid), W'(1));
    chk_group("clr", g);

    // ---- reset mid-group while out_valid ----
    do_reset();
    for (int k = 1; k <= 11; k++) send(32'hC000_0000 + 32'(k));
    chk("pre-rst out_valid", W'(out_valid), W'(1));
    chk("pre-rst word_cnt", W'(word_cnt), W'(3));
    rst = 1'b1; in_valid = 1'b1; out_ack = 1'b1; D = 32'hC000_00FF;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst word_cnt", W'(word_cnt), W'(0));
    chk("rst in_ready", W'(in_ready), W'(1));
    chk_group("rst", '0);

    // ---- random gaps and acks, scoreboard ----
    do_reset();
    sb.delete();
    sent = 0; mcnt = 0; cycles = 0; taken = 0;
    while ((sent < 64 || sb.size() > 0 || out_valid) && cycles < 3000) begin
      in_valid = (sent < 64) && ($urandom_range(0, 1) == 1);
      mode     = 1'($urandom_range(0, 1));
      D        = $urandom;
      out_ack  = (sent < 64) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) begin
        cur[mcnt] = mode ? swp(D) : D;
        mcnt++;
        sent++;
        if (mcnt == 8) begin
          sb.push_back(cur);
          mcnt = 0;
        end
      end
      if (out_ack && out_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL rand extra group: got group with Q0=0x%08h expected none", Q0);
        end else begin
          g = sb.pop_front();
          chk_group($sformatf("rand g%0d", taken), g);
        end
        taken++;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0; out_ack = 1'b0;
    chk("rand cycle budget", W'(cycles < 3000), W'(1));
    chk("rand groups taken", W'(taken), W'(8));
    chk("rand scoreboard empty", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_input_circuit
